song_sequencer: RTL and testbench

- Playback controller for the melody datapath: melody ROM (synchronous read, 1-cycle latency) → tone-code mapper → speaker divider.
- Generates the melody ROM address, paces notes on a beat period, and selects among several songs stored back-to-back in the ROM.
- Provides play/pause, stop, next-song and loop control from debounced single-cycle key pulses.
- Replaces the free-running note address counter in the top level.

---
 rtl/song_pkg.sv | 29 ++
 rtl/beat_timer.sv | 47 ++++
 rtl/song_sequencer.sv | 167 ++++++++++++++++
 tb/tb_song_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg
// Shared definitions for the melody playback controller:
//   - state_t     : playback FSM states
//   - SONG_START  : first melody ROM address of each song
//   - SONG_END    : last melody ROM address of each song (inclusive)
//   - REST        : note index meaning "silence"
// The table holds TBL_SONGS entries of TBL_ADDR_W bits; song 0 occupies
// addresses 0..26 of the existing melody ROM, the rest follow back-to-back.
// ---------------------------------------------------------------------------
package song_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StHold,
        StPause
    } state_t;

    localparam int unsigned TBL_SONGS  = 4;
    localparam int unsigned TBL_ADDR_W = 8;

    localparam logic [TBL_ADDR_W-1:0] SONG_START [TBL_SONGS] = '{8'd0, 8'd27, 8'd59, 8'd91};
    localparam logic [TBL_ADDR_W-1:0] SONG_END   [TBL_SONGS] = '{8'd26, 8'd58, 8'd90, 8'd122};

    localparam int unsigned REST = 0;

endpackage

// File: rtl/beat_timer.sv
// ---------------------------------------------------------------------------
// beat_timer
// Note-slot counter. Counts enabled cycles and raises tc on the terminal
// count, then wraps to 0. The terminal is BEAT_DIV-3 because the FETCH and
// LATCH cycles of each slot are spent outside the counting state.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous reset, active-high
//   en   in   count this cycle (counter holds when low)
//   clr  in   synchronous clear, overrides en
//   tc   out  1 while enabled and at the terminal count
// ---------------------------------------------------------------------------
module beat_timer #(
    parameter int unsigned BEAT_DIV = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(BEAT_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(BEAT_DIV - 3);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
// Playback controller for the melody datapath (melody ROM -> tone mapper ->
// speaker divider). Walks the ROM address through the current song, paces
// notes on a BEAT_DIV-cycle slot and handles play/pause, stop, next-song and
// loop control.
// Ports:
//   CLK0      in   system clock
//   RST0      in   asynchronous reset, active-high
//   KEY_PLAY  in   1-cycle pulse, play/pause toggle
//   KEY_STOP  in   1-cycle pulse, stop and rewind
//   KEY_NEXT  in   1-cycle pulse, select next song
//   LOOP      in   level, restart song after its last note
//   ROM_ADDR  out  melody ROM address (registered)
//   ROM_DATA  in   melody ROM data, valid 1 cycle after ROM_ADDR
//   NOTE_OUT  out  note index to the tone mapper, 0 when not sounding
//   SONG_IDX  out  current song
//   PLAYING   out  1 in FETCH, LATCH or HOLD
//   BEAT      out  1-cycle pulse at the end of each note slot
// ---------------------------------------------------------------------------
module song_sequencer
    import song_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BEAT_DIV  = 12500000,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NOTE_W    = 4,
    parameter int unsigned NUM_SONGS = 4,
    parameter int unsigned SONG_W    = 2
) (
    input  logic              CLK0,
    input  logic              RST0,
    input  logic              KEY_PLAY,
    input  logic              KEY_STOP,
    input  logic              KEY_NEXT,
    input  logic              LOOP,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [NOTE_W-1:0] ROM_DATA,
    output logic [NOTE_W-1:0] NOTE_OUT,
    output logic [SONG_W-1:0] SONG_IDX,
    output logic              PLAYING,
    output logic              BEAT
);

    state_t            state_q, state_d;
    logic [SONG_W-1:0] song_q, song_d, song_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [ADDR_W-1:0] cur_start, cur_end, nxt_start;
    logic              key_stop, key_next, key_play;
    logic              run, tc, tmr_en, tmr_clr;
    logic              unused_cfg;

    // CLK_HZ is informational only.
    assign unused_cfg = (CLK_HZ == 0);

    // Key priority: STOP > NEXT > PLAY.
    assign key_stop = KEY_STOP;
    assign key_next = KEY_NEXT && !KEY_STOP;
    assign key_play = KEY_PLAY && !KEY_NEXT && !KEY_STOP;

    assign song_inc  = (song_q == SONG_W'(NUM_SONGS - 1)) ? '0 : song_q + 1'b1;
    assign cur_start = ADDR_W'(SONG_START[song_q]);
    assign cur_end   = ADDR_W'(SONG_END[song_q]);
    assign nxt_start = ADDR_W'(SONG_START[song_inc]);

    assign run = (state_q == StFetch) || (state_q == StLatch) || (state_q == StHold);

    // Any key in HOLD freezes the counter, so a key landing on the terminal
    // count also swallows that slot's advance and BEAT pulse.
    assign tmr_en  = (state_q == StHold) && !(KEY_STOP || KEY_NEXT || KEY_PLAY);
    assign tmr_clr = key_stop || key_next || (state_q == StLatch) || (state_q == StIdle);

    beat_timer #(
        .BEAT_DIV (BEAT_DIV)
    ) u_beat_timer (
        .clk (CLK0),
        .rst (RST0),
        .en  (tmr_en),
        .clr (tmr_clr),
        .tc  (tc)
    );

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        addr_d  = addr_q;
        note_d  = note_q;

        unique case (state_q)
            StIdle: begin
                if (key_play) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                note_d  = ROM_DATA;
                state_d = StHold;
            end
            StHold: begin
                if (key_play) begin
                    state_d = StPause;
                end else if (tc) begin
                    if (addr_q == cur_end) begin
                        addr_d = cur_start;
                        if (LOOP) begin
                            state_d = StFetch;
                        end else begin
                            state_d = StIdle;
                            note_d  = NOTE_W'(REST);
                        end
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StPause: begin
                if (key_play) begin
                    state_d = StHold;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // New song starts silent; playback continues only if it was sounding.
        if (key_next) begin
            song_d  = song_inc;
            addr_d  = nxt_start;
            note_d  = NOTE_W'(REST);
            state_d = run ? StFetch : StIdle;
        end

        if (key_stop) begin
            state_d = StIdle;
            addr_d  = cur_start;
            note_d  = NOTE_W'(REST);
        end
    end

    always_ff @(posedge CLK0 or posedge RST0) begin
        if (RST0) begin
            state_q <= StIdle;
            song_q  <= '0;
            addr_q  <= ADDR_W'(SONG_START[0]);
            note_q  <= NOTE_W'(REST);
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
        end
    end

    // The latched note survives PAUSE internally but is muted on the output.
    assign NOTE_OUT = run ? note_q : NOTE_W'(REST);
    assign ROM_ADDR = addr_q;
    assign SONG_IDX = song_q;
    assign PLAYING  = run;
    assign BEAT     = tc;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

    localparam int unsigned BEAT_DIV  = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned NOTE_W    = 4;
    localparam int unsigned NUM_SONGS = 4;
    localparam int unsigned SONG_W    = 2;

    logic              CLK0 = 1'b0;
    logic              RST0 = 1'b1;
    logic              KEY_PLAY = 1'b0;
    logic              KEY_STOP = 1'b0;
    logic              KEY_NEXT = 1'b0;
    logic              LOOP = 1'b0;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic [NOTE_W-1:0] ROM_DATA;
    logic [NOTE_W-1:0] NOTE_OUT;
    logic [SONG_W-1:0] SONG_IDX;
    logic              PLAYING;
    logic              BEAT;

    song_sequencer #(
        .CLK_HZ    (50000000),
        .BEAT_DIV  (BEAT_DIV),
        .ADDR_W    (ADDR_W),
        .NOTE_W    (NOTE_W),
        .NUM_SONGS (NUM_SONGS),
        .SONG_W    (SONG_W)
    ) dut (
        .CLK0     (CLK0),
        .RST0     (RST0),
        .KEY_PLAY (KEY_PLAY),
        .KEY_STOP (KEY_STOP),
        .KEY_NEXT (KEY_NEXT),
        .LOOP     (LOOP),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA),
        .NOTE_OUT (NOTE_OUT),
        .SONG_IDX (SONG_IDX),
        .PLAYING  (PLAYING),
        .BEAT     (BEAT)
    );

    always #5 CLK0 = ~CLK0;

    // Melody ROM with 1-cycle synchronous read.
    logic [NOTE_W-1:0] rom [256];
    always_ff @(posedge CLK0) ROM_DATA <= rom[ROM_ADDR];

    // Song table: song 0 at 0..26, the others packed back-to-back.
    int s_start [NUM_SONGS] = '{0, 27, 59, 91};
    int s_end   [NUM_SONGS] = '{26, 58, 90, 122};

    int checks = 0;
    int passes = 0;

    // Reference model: position within a note slot of BEAT_DIV cycles
    // (0 = address presented, 1 = data returning, 2.. = note sounding).
    bit              m_active;
    bit              m_paused;
    int              m_song;
    int              m_k;
    int              m_pos;
    logic [NOTE_W-1:0] m_cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_paused = 1'b0;
        m_song   = 0;
        m_k      = 0;
        m_pos    = 0;
        m_cur    = '0;
    endtask

    task automatic check_outputs(input bit s, input bit n, input bit p);
        bit sounding;
        sounding = m_active && !m_paused;
        check("ROM_ADDR", 32'(ROM_ADDR), 32'(s_start[m_song] + (m_active ? m_k : 0)));
        check("NOTE_OUT", 32'(NOTE_OUT), sounding ? 32'(m_cur) : 32'd0);
        check("SONG_IDX", 32'(SONG_IDX), 32'(m_song));
        check("PLAYING", 32'(PLAYING), 32'(sounding));
        check("BEAT", 32'(BEAT),
              32'(sounding && (m_pos == int'(BEAT_DIV) - 1) && !(s || n || p)));
    endtask

    task automatic model_edge(input bit s, input bit n, input bit p, input bit lp);
        int len;
        len = s_end[m_song] - s_start[m_song] + 1;
        if (s) begin
            m_active = 1'b0;
            m_paused = 1'b0;
            m_k      = 0;
            m_pos    = 0;
            m_cur    = '0;
        end else if (n) begin
            m_song   = (m_song + 1) % NUM_SONGS;
            m_k      = 0;
            m_pos    = 0;
            m_cur    = '0;
            m_active = m_active && !m_paused;
            m_paused = 1'b0;
        end else if (!m_active) begin
            if (p) m_active = 1'b1;
        end else if (m_paused) begin
            if (p) m_paused = 1'b0;
        end else if (p && m_pos >= 2) begin
            m_paused = 1'b1;
        end else if (m_pos == int'(BEAT_DIV) - 1) begin
            if (m_k == len - 1) begin
                m_k   = 0;
                m_pos = 0;
                if (!lp) begin
                    m_active = 1'b0;
                    m_cur    = '0;
                end
            end else begin
                m_k++;
                m_pos = 0;
            end
        end else begin
            if (m_pos == 1) m_cur = rom[s_start[m_song] + m_k];
            m_pos++;
        end
    endtask

    task automatic cycle(input bit s, input bit n, input bit p);
        @(negedge CLK0);
        KEY_STOP = s;
        KEY_NEXT = n;
        KEY_PLAY = p;
        #1;
        check_outputs(s, n, p);
        @(posedge CLK0);
        model_edge(s, n, p, LOOP);
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int guard;
        int r;

        for (int i = 0; i < 256; i++) rom[i] = NOTE_W'($urandom_range(0, 15));
        rom[0] = 4'd3;
        rom[1] = 4'd3;
        rom[2] = 4'd0;
        rom[3] = 4'd5;
        model_reset();

        // Reset state.
        #12;
        check_outputs(1'b0, 1'b0, 1'b0);
        @(negedge CLK0);
        RST0 = 1'b0;

        // Basic play of song 0 to the end, no loop.
        LOOP = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        run(27 * BEAT_DIV + 10);

        // Loop: song wraps back to its first note without stopping.
        LOOP = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        run(27 * BEAT_DIV + 20);
        LOOP = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        run(3);

        // Pause 3 cycles into note 2, hold 20 cycles, resume.
        cycle(1'b0, 1'b0, 1'b1);
        guard = 0;
        while ((m_k != 1 || m_pos != 5) && guard < 100) begin
            cycle(1'b0, 1'b0, 1'b0);
            guard++;
        end
        cycle(1'b0, 1'b0, 1'b1);
        run(20);
        cycle(1'b0, 1'b0, 1'b1);
        run(2 * BEAT_DIV);
        cycle(1'b1, 1'b0, 1'b0);

        // Next-song: reach song 3 from idle, play, wrap to song 0 mid-play.
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        run(15);
        cycle(1'b0, 1'b1, 1'b0);
        run(12);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        run(3);

        // All three keys at once during HOLD: stop wins.
        cycle(1'b0, 1'b0, 1'b1);
        run(12);
        cycle(1'b1, 1'b1, 1'b1);
        run(4);

        // Randomized key traffic with occasional LOOP changes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) LOOP = ~LOOP;
            r = int'($urandom_range(0, 99));
            if (r == 5) cycle(1'b1, 1'b1, 1'b1);
            else cycle(r == 0, r == 1, (r >= 2 && r <= 4));
        end

        // Asynchronous reset in the middle of a note on a non-zero song.
        LOOP = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        run(12);
        @(posedge CLK0);
        #3;
        RST0 = 1'b1;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 1'b0);
        @(negedge CLK0);
        RST0 = 1'b0;
        run(10);
        cycle(1'b0, 1'b0, 1'b1);
        run(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
